// File: rtl/pulse_meter.sv
// pulse_meter: measures high/low widths (in clocks) of each rise-to-rise period of `signal`.
// Define PULSE_METER_SYNC_EN to sample `signal` through a 2-flop synchronizer.
module pulse_meter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             signal,
    input  logic             ack,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] low_count,
    output logic             valid,
    output logic             sat,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] hcnt_next;
    logic [WIDTH-1:0] lcnt;
    logic [WIDTH-1:0] lcnt_next;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic             publish;

    // Sample flops reset high so a line already high at release is not seen as a rise.
`ifdef PULSE_METER_SYNC_EN
    logic meta;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            meta <= 1'b1;
            s    <= 1'b1;
            s_d  <= 1'b1;
        end else begin
            meta <= signal;
            s    <= meta;
            s_d  <= s;
        end
    end
`else
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            s   <= 1'b1;
            s_d <= 1'b1;
        end else begin
            s   <= signal;
            s_d <= s;
        end
    end
`endif

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_next;
            hcnt  <= hcnt_next;
            lcnt  <= lcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        hcnt_next  = hcnt;
        lcnt_next  = lcnt;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HIGH;
                    hcnt_next  = ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_next = LOW;
                    lcnt_next  = ONE;
                end else begin
                    hcnt_next = sat_inc(hcnt);
                end
            end
            LOW: begin
                if (rise) begin
                    publish    = 1'b1;
                    state_next = HIGH;
                    hcnt_next  = ONE;
                end else begin
                    lcnt_next = sat_inc(lcnt);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A publish that lands on an unacknowledged result flags overrun; a same-edge ack absorbs it.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            high_count <= '0;
            low_count  <= '0;
            valid      <= 1'b0;
            sat        <= 1'b0;
            overrun    <= 1'b0;
        end else if (publish) begin
            high_count <= hcnt;
            low_count  <= lcnt;
            sat        <= (hcnt == MAX) | (lcnt == MAX);
            valid      <= 1'b1;
            overrun    <= valid & ~ack;
        end else if (valid && ack) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

endmodule
